// File: rtl/uart_reg_bridge_if.sv
// Bridge-side bundle of the RX FIFO pop port, TX FIFO push port and 32-bit req/ack register bus.
// master = the bridge, slave = the FIFOs and register target around it.
interface uart_reg_bridge_if;
    logic        i_rx_empty;
    logic [7:0]  i_rx_rdata;
    logic        o_rx_read;
    logic        i_tx_full;
    logic        o_tx_write;
    logic [7:0]  o_tx_wdata;
    logic        o_reg_req;
    logic        o_reg_we;
    logic [7:0]  o_reg_addr;
    logic [31:0] o_reg_wdata;
    logic        i_reg_ack;
    logic [31:0] i_reg_rdata;

    modport master (
        input  i_rx_empty, i_rx_rdata, i_tx_full, i_reg_ack, i_reg_rdata,
        output o_rx_read, o_tx_write, o_tx_wdata, o_reg_req, o_reg_we, o_reg_addr, o_reg_wdata
    );

    modport slave (
        output i_rx_empty, i_rx_rdata, i_tx_full, i_reg_ack, i_reg_rdata,
        input  o_rx_read, o_tx_write, o_tx_wdata, o_reg_req, o_reg_we, o_reg_addr, o_reg_wdata
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// Decodes 'W'/'R' UART command frames into one 32-bit req/ack access and pushes the response bytes.
// One RX byte/cycle, req the cycle after the last byte, TX full stalls RESP; UART_BRIDGE_TIMEOUT_EN adds an inter-byte timeout.
module uart_reg_bridge #(
    parameter int TimeoutBits = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [TimeoutBits-1:0] c_timeout_cyc,
    uart_reg_bridge_if.master      bus,
    output logic                   o_busy,
    output logic                   o_timeout
);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic        rx_read, tx_write, pop;

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [TimeoutBits-1:0] tmo_q, tmo_d, tmo_inc;
    logic                   timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        resp_d   = resp_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        rx_read  = 1'b0;
        tx_write = 1'b0;
        pop      = !bus.i_rx_empty;
        case (state_q)
            IDLE: begin
                rx_read = pop;
                if (pop) begin
                    cnt_d = 2'd0;
                    case (bus.i_rx_rdata)
                        8'h57: begin we_d = 1'b1; state_d = ADDR; end
                        8'h52: begin we_d = 1'b0; state_d = ADDR; end
                        default: begin
                            resp_d  = 32'h0000_003F;
                            last_d  = 2'd0;
                            state_d = RESP;
                        end
                    endcase
                end
            end
            ADDR: begin
                rx_read = pop;
                if (pop) begin
                    addr_d  = bus.i_rx_rdata;
                    cnt_d   = 2'd0;
                    state_d = we_q ? WDATA : BUS;
                end
            end
            WDATA: begin
                rx_read = pop;
                if (pop) begin
                    // LSB byte arrives first, so shift in from the top.
                    wdata_d = {bus.i_rx_rdata, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = BUS;
                end
            end
            BUS: begin
                if (bus.i_reg_ack) begin
                    resp_d  = we_q ? 32'h0000_004B : bus.i_reg_rdata;
                    last_d  = we_q ? 2'd0 : 2'd3;
                    cnt_d   = 2'd0;
                    state_d = RESP;
                end
            end
            RESP: begin
                tx_write = !bus.i_tx_full;
                if (!bus.i_tx_full) begin
                    resp_d = {8'h00, resp_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == last_q) begin
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef UART_BRIDGE_TIMEOUT_EN
        tmo_d     = '0;
        timeout_d = 1'b0;
        tmo_inc   = tmo_q + TimeoutBits'(1);
        if ((state_q == ADDR || state_q == WDATA) && !pop) begin
            tmo_d = tmo_inc;
            // Zero threshold means never time out.
            if (c_timeout_cyc != '0 && tmo_inc == c_timeout_cyc) begin
                tmo_d     = '0;
                timeout_d = 1'b1;
                cnt_d     = 2'd0;
                state_d   = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 32'h0;
            resp_q  <= 32'h0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^c_timeout_cyc;
    assign o_timeout  = 1'b0;
`endif

    assign bus.o_rx_read   = rx_read;
    assign bus.o_tx_write  = tx_write;
    assign bus.o_tx_wdata  = resp_q[7:0];
    assign bus.o_reg_req   = (state_q == BUS);
    assign bus.o_reg_we    = we_q;
    assign bus.o_reg_addr  = addr_q;
    assign bus.o_reg_wdata = wdata_q;
    assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: RX FIFO / TX FIFO / register target models around a table of frames.
`timescale 1ns/1ps
module tb_uart_reg_bridge;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] c_timeout_cyc = 16'd0;
    logic        o_busy, o_timeout;

    always #5 i_clk = ~i_clk;

    uart_reg_bridge_if bus();

    uart_reg_bridge #(.TimeoutBits(16)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .c_timeout_cyc (c_timeout_cyc),
        .bus           (bus),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    logic        rx_empty = 1'b1;
    logic [7:0]  rx_rdata = 8'h00;
    logic        tx_full = 1'b0;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] rsp_rdata = 32'h0;

    assign bus.i_rx_empty  = rx_empty;
    assign bus.i_rx_rdata  = rx_rdata;
    assign bus.i_tx_full   = tx_full;
    assign bus.i_reg_ack   = resp_ack | stray_ack;
    assign bus.i_reg_rdata = rsp_rdata;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int         txcyc[$];
    int cyc = 0, pops = 0, first_pop_cyc = -1, last_pop_cyc = -1, ack_cyc = -1;
    int tx_while_full = 0, tmo_pulses = 0, tmo_cyc = -1;
    int req_events = 0, req_age = 0, unstable = 0, ack_delay = 0;
    logic        rec_we;
    logic [7:0]  rec_addr;
    logic [31:0] rec_wdata;
    int n_checks = 0, n_fail = 0;

    // FIFO models: sample the DUT at the edge, update the RX head just after it.
    always @(posedge i_clk) begin
        logic do_pop;
        do_pop = 1'b0;
        if (i_rst_n) begin
            if (bus.o_rx_read) begin
                do_pop = 1'b1;
                pops++;
                last_pop_cyc = cyc;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (bus.o_tx_write) begin
                if (tx_full) tx_while_full++;
                else begin
                    txq.push_back(bus.o_tx_wdata);
                    txcyc.push_back(cyc);
                end
            end
            if (resp_ack) ack_cyc = cyc;
            if (o_timeout) begin
                tmo_pulses++;
                tmo_cyc = cyc;
            end
        end
        cyc++;
        #1;
        if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty = (rxq.size() == 0);
        rx_rdata = rx_empty ? 8'h00 : rxq[0];
    end

    // Register target: records each request, checks stability, acks after ack_delay extra cycles.
    always @(negedge i_clk) begin
        if (resp_ack) resp_ack = 1'b0;
        else if (i_rst_n && bus.o_reg_req) begin
            if (req_age == 0) begin
                req_events++;
                rec_we    = bus.o_reg_we;
                rec_addr  = bus.o_reg_addr;
                rec_wdata = bus.o_reg_wdata;
            end else if (bus.o_reg_we !== rec_we || bus.o_reg_addr !== rec_addr ||
                         bus.o_reg_wdata !== rec_wdata) begin
                unstable++;
            end
            if (req_age >= ack_delay) begin
                resp_ack = 1'b1;
                req_age  = 0;
            end else req_age++;
        end else req_age = 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]  n;
        logic [47:0] frame;
        logic [7:0]  dly;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [2:0]  exp_n;
        logic [31:0] exp_tx;
        logic [1:0]  tchk;
    } vec_t;

    task automatic clear_trackers();
        txq.delete();
        txcyc.delete();
        req_events    = 0;
        first_pop_cyc = -1;
        ack_cyc       = -1;
    endtask

    task automatic push_frame(input logic [47:0] frame, input int n);
        for (int j = 0; j < n; j++) rxq.push_back(frame[8*j +: 8]);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int en;
        logic [31:0] etx;
        en  = int'(v.exp_n);
        etx = v.exp_tx;
        @(negedge i_clk);
        clear_trackers();
        ack_delay = int'(v.dly);
        rsp_rdata = v.rdata;
        push_frame(v.frame, int'(v.n));
        for (int k = 0; k < 300; k++) begin
            if (txq.size() >= en && !o_busy) break;
            @(negedge i_clk);
        end
        repeat (2) @(negedge i_clk);
        check({tag, " busy_done"}, {31'd0, o_busy}, 32'd0);
        check({tag, " req_count"}, req_events, {31'd0, v.exp_req});
        if (v.exp_req) begin
            check({tag, " we"}, {31'd0, rec_we}, {31'd0, v.exp_we});
            check({tag, " addr"}, {24'd0, rec_addr}, {24'd0, v.exp_addr});
            if (v.exp_we) check({tag, " wdata"}, rec_wdata, v.exp_wdata);
        end
        check({tag, " tx_count"}, txq.size(), en);
        if (txq.size() == en) begin
            for (int j = 0; j < en; j++)
                check($sformatf("%s tx_byte%0d", tag, j), {24'd0, txq[j]}, {24'd0, etx[8*j +: 8]});
            if (v.tchk == 2'd1 && en == 4) begin
                check({tag, " first_push_cyc"}, txcyc[0], ack_cyc + 1);
                check({tag, " last_push_cyc"}, txcyc[3], ack_cyc + 4);
            end
            if (v.tchk == 2'd2)
                check({tag, " min_write_cycles"}, txcyc[0] - first_pop_cyc, 32'd7);
        end
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        vecs[0] = '{n:3'd6, frame:48'hDEAD_BEEF_1057, dly:8'd3, rdata:32'h0, exp_req:1'b1, exp_we:1'b1,
                    exp_addr:8'h10, exp_wdata:32'hDEAD_BEEF, exp_n:3'd1, exp_tx:32'h4B, tchk:2'd0};
        vecs[1] = '{n:3'd2, frame:48'h2052, dly:8'd0, rdata:32'h1234_5678, exp_req:1'b1, exp_we:1'b0,
                    exp_addr:8'h20, exp_wdata:32'h0, exp_n:3'd4, exp_tx:32'h1234_5678, tchk:2'd1};
        vecs[2] = '{n:3'd1, frame:48'h41, dly:8'd0, rdata:32'h0, exp_req:1'b0, exp_we:1'b0,
                    exp_addr:8'h00, exp_wdata:32'h0, exp_n:3'd1, exp_tx:32'h3F, tchk:2'd0};
        vecs[3] = '{n:3'd2, frame:48'h0052, dly:8'd1, rdata:32'hA5A5_0F0F, exp_req:1'b1, exp_we:1'b0,
                    exp_addr:8'h00, exp_wdata:32'h0, exp_n:3'd4, exp_tx:32'hA5A5_0F0F, tchk:2'd1};
        vecs[4] = '{n:3'd6, frame:48'h0403_0201_FF57, dly:8'd0, rdata:32'h0, exp_req:1'b1, exp_we:1'b1,
                    exp_addr:8'hFF, exp_wdata:32'h0403_0201, exp_n:3'd1, exp_tx:32'h4B, tchk:2'd2};
        vecs[5] = '{n:3'd1, frame:48'h00, dly:8'd0, rdata:32'h0, exp_req:1'b0, exp_we:1'b0,
                    exp_addr:8'h00, exp_wdata:32'h0, exp_n:3'd1, exp_tx:32'h3F, tchk:2'd0};
`ifdef UART_BRIDGE_TIMEOUT_EN
        c_timeout_cyc = 16'd50;
`endif

        // Reset values, both during and after reset.
        repeat (3) @(negedge i_clk);
        check("rst_req_in_reset", {31'd0, bus.o_reg_req}, 32'd0);
        check("rst_busy_in_reset", {31'd0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_req", {31'd0, bus.o_reg_req}, 32'd0);
        check("rst_we", {31'd0, bus.o_reg_we}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_tx_write", {31'd0, bus.o_tx_write}, 32'd0);
        check("rst_rx_read", {31'd0, bus.o_rx_read}, 32'd0);
        check("rst_tx_wdata", {24'd0, bus.o_tx_wdata}, 32'd0);
        check("rst_addr", {24'd0, bus.o_reg_addr}, 32'd0);
        check("rst_wdata", bus.o_reg_wdata, 32'd0);
        check("rst_timeout", {31'd0, o_timeout}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Ack while idle must be ignored.
        @(negedge i_clk);
        clear_trackers();
        rsp_rdata = 32'hFFFF_FFFF;
        stray_ack = 1'b1;
        @(negedge i_clk);
        stray_ack = 1'b0;
        repeat (5) @(negedge i_clk);
        check("stray_ack_busy", {31'd0, o_busy}, 32'd0);
        check("stray_ack_tx", txq.size(), 32'd0);
        check("stray_ack_tx_wdata", {24'd0, bus.o_tx_wdata}, 32'd0);

        // TX backpressure: read response stalls, the queued opcode behind it is not popped.
        @(negedge i_clk);
        clear_trackers();
        tx_full   = 1'b1;
        ack_delay = 0;
        rsp_rdata = 32'h1234_5678;
        pops      = 0;
        push_frame(48'h41_2052, 3);
        for (int k = 0; k < 100 && ack_cyc < 0; k++) @(negedge i_clk);
        check("bp_ack_seen", {31'd0, ack_cyc >= 0}, 32'd1);
        repeat (10) @(negedge i_clk);
        check("bp_no_push", txq.size(), 32'd0);
        check("bp_tx_write_low", {31'd0, bus.o_tx_write}, 32'd0);
        check("bp_pops_held", pops, 32'd2);
        check("bp_busy", {31'd0, o_busy}, 32'd1);
        tx_full = 1'b0;
        for (int k = 0; k < 100 && (txq.size() < 5 || o_busy); k++) @(negedge i_clk);
        check("bp_tx_count", txq.size(), 32'd5);
        check("bp_push_while_full", tx_while_full, 32'd0);
        if (txq.size() == 5) begin
            check("bp_byte0", {24'd0, txq[0]}, 32'h78);
            check("bp_byte1", {24'd0, txq[1]}, 32'h56);
            check("bp_byte2", {24'd0, txq[2]}, 32'h34);
            check("bp_byte3", {24'd0, txq[3]}, 32'h12);
            check("bp_byte4_bad_op", {24'd0, txq[4]}, 32'h3F);
        end

`ifdef UART_BRIDGE_TIMEOUT_EN
        // Partial write frame is dropped after 50 idle cycles.
        @(negedge i_clk);
        clear_trackers();
        tmo_pulses = 0;
        push_frame(48'hAA_1057, 3);
        repeat (70) @(negedge i_clk);
        check("tmo_pulses", tmo_pulses, 32'd1);
        check("tmo_cycle", tmo_cyc - last_pop_cyc, 32'd51);
        check("tmo_no_req", req_events, 32'd0);
        check("tmo_no_tx", txq.size(), 32'd0);
        check("tmo_idle", {31'd0, o_busy}, 32'd0);
        v = '{n:3'd2, frame:48'h0052, dly:8'd0, rdata:32'h0BAD_CAFE, exp_req:1'b1, exp_we:1'b0,
              exp_addr:8'h00, exp_wdata:32'h0, exp_n:3'd4, exp_tx:32'h0BAD_CAFE, tchk:2'd1};
        run_vec("post_tmo", v);
`endif

        // Reset while a request is outstanding.
        @(negedge i_clk);
        clear_trackers();
        ack_delay = 200;
        push_frame(48'h3052, 2);
        for (int k = 0; k < 50 && !bus.o_reg_req; k++) @(negedge i_clk);
        check("rstbus_req_seen", {31'd0, bus.o_reg_req}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("rstbus_req", {31'd0, bus.o_reg_req}, 32'd0);
        check("rstbus_busy", {31'd0, o_busy}, 32'd0);
        check("rstbus_tx_write", {31'd0, bus.o_tx_write}, 32'd0);
        check("rstbus_addr", {24'd0, bus.o_reg_addr}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        v = '{n:3'd2, frame:48'h4052, dly:8'd0, rdata:32'hCAFE_F00D, exp_req:1'b1, exp_we:1'b0,
              exp_addr:8'h40, exp_wdata:32'h0, exp_n:3'd4, exp_tx:32'hCAFE_F00D, tchk:2'd1};
        run_vec("post_rst", v);

        check("req_stable", unstable, 32'd0);
        check("no_push_while_full", tx_while_full, 32'd0);
`ifndef UART_BRIDGE_TIMEOUT_EN
        check("timeout_never", tmo_pulses, 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
